// File: rtl/mul_seq_if.sv
// Start/ready handshake bundle between the execute stage (master) and a
// multi-cycle responder such as mul_seq (slave).
interface mul_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 signed_mul_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;

    modport master (
        output signed_mul_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_mul_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier with fixed WIDTH-cycle iteration, signed via
// magnitude multiply and final conditional negate; start/ready responder.
module mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic     clk,
    input logic     rst,
    mul_seq_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             neg_q, neg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    result_q, result_d;
    logic             ready_q, ready_d;

    logic [WIDTH-1:0] abs1, abs2;
    logic [PW-1:0]    step_acc, step_res;

    always_comb begin
        abs1 = (bus.signed_mul_i && bus.opdata1_i[WIDTH-1]) ? (~bus.opdata1_i + WIDTH'(1))
                                                            : bus.opdata1_i;
        abs2 = (bus.signed_mul_i && bus.opdata2_i[WIDTH-1]) ? (~bus.opdata2_i + WIDTH'(1))
                                                            : bus.opdata2_i;
        // Multiplicand is pre-shifted each step, so mcand_q == multiplicand << cnt.
        step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
        step_res = neg_q ? (~step_acc + PW'(1)) : step_acc;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ready_d  = ready_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    state_d  = S_RUN;
                    mcand_d  = {{WIDTH{1'b0}}, abs1};
                    mplier_d = abs2;
                    neg_d    = bus.signed_mul_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                if (bus.annul_i) begin
                    state_d  = S_IDLE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    acc_d    = step_acc;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d  = S_DONE;
                        result_d = step_res;
                        ready_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (bus.annul_i || !bus.start_i) begin
                    state_d  = S_IDLE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule
